mmio_bridge: RTL and testbench

- Sits between the processor's dmem port and the dmem syncram, directly downstream of the processor/memory top level.
- Decodes the 12-bit data address. The top 16 words (0xFF0-0xFFF) form a memory-mapped I/O window; all other addresses pass through to dmem.
- The window contains game-state output registers that feed the display logic. It also contains a buffered PS/2 key-code queue and a status word that the processor reads with ordinary lw/sw.

---
 rtl/mmio_bridge.sv | 146 ++++++++++++++
 tb/tb_mmio_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// Address-decoding bridge between the processor dmem port and the dmem syncram.
// The top 16 words hold display registers, a PS/2 key-code FIFO and a status word.
module mmio_bridge #(
   parameter int          KEY_DEPTH = 8,
   parameter logic [11:0] IO_BASE   = 12'hFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] proc_addr,
   input  logic [31:0] proc_wdata,
   input  logic        proc_wren,
   input  logic        proc_ren,
   output logic [31:0] proc_rdata,
   output logic [11:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        dmem_wren,
   input  logic [31:0] dmem_q,
   input  logic [7:0]  key_code,
   input  logic        key_valid,
   input  logic        vsync_pulse,
   output logic [9:0]  player_x,
   output logic [8:0]  player_y,
   output logic [7:0]  scene_id,
   output logic [31:0] score
);

   localparam int PW = $clog2(KEY_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(KEY_DEPTH);

   localparam logic [3:0] OFF_X      = 4'h0;
   localparam logic [3:0] OFF_Y      = 4'h1;
   localparam logic [3:0] OFF_SCENE  = 4'h2;
   localparam logic [3:0] OFF_SCORE  = 4'h3;
   localparam logic [3:0] OFF_STATUS = 4'hE;
   localparam logic [3:0] OFF_KEY    = 4'hF;

   logic [9:0]    r_player_x;
   logic [8:0]    r_player_y;
   logic [7:0]    r_scene_id;
   logic [31:0]   r_score;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          r_vsync_seen;
   logic [7:0]    r_fifo_mem [KEY_DEPTH];

   logic          w_io_hit;
   logic [3:0]    w_io_off;
   logic          w_io_wr;
   logic          w_status_rd;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_non_empty;
   logic [31:0]   w_status;
   logic [31:0]   w_io_rdata;

   assign w_io_hit    = (proc_addr[11:4] == IO_BASE[11:4]);
   assign w_io_off    = proc_addr[3:0];
   assign w_io_wr     = proc_wren & w_io_hit;
   assign w_status_rd = proc_ren & w_io_hit & (w_io_off == OFF_STATUS);
   assign w_non_empty = (r_count != '0);
   assign w_pop       = proc_ren & ~proc_wren & w_io_hit & (w_io_off == OFF_KEY) & w_non_empty;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept the key.
   assign w_push      = key_valid & ((r_count < DEPTH_C) | w_pop);
   assign w_drop      = key_valid & ~w_push;

   assign dmem_addr  = proc_addr;
   assign dmem_wdata = proc_wdata;
   assign dmem_wren  = proc_wren & ~w_io_hit;
   assign proc_rdata = w_io_hit ? w_io_rdata : dmem_q;

   assign player_x = r_player_x;
   assign player_y = r_player_y;
   assign scene_id = r_scene_id;
   assign score    = r_score;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      w_status      = '0;
      w_status[0]   = w_non_empty;
      w_status[5:1] = 5'(r_count);
      w_status[8]   = r_overflow;
      w_status[9]   = r_vsync_seen;
   end

   always_comb begin
      w_io_rdata = '0;
      unique case (w_io_off)
         OFF_X:      w_io_rdata = {22'b0, r_player_x};
         OFF_Y:      w_io_rdata = {23'b0, r_player_y};
         OFF_SCENE:  w_io_rdata = {24'b0, r_scene_id};
         OFF_SCORE:  w_io_rdata = r_score;
         OFF_STATUS: w_io_rdata = w_status;
         OFF_KEY:    w_io_rdata = w_non_empty ? {24'b0, r_fifo_mem[r_rd_ptr]} : 32'b0;
         default:    w_io_rdata = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_player_x <= '0;
         r_player_y <= '0;
         r_scene_id <= '0;
         r_score    <= '0;
      end else if (w_io_wr) begin
         unique case (w_io_off)
            OFF_X:     r_player_x <= proc_wdata[9:0];
            OFF_Y:     r_player_y <= proc_wdata[8:0];
            OFF_SCENE: r_scene_id <= proc_wdata[7:0];
            OFF_SCORE: r_score    <= proc_wdata;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_vsync_seen <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;

         if (w_drop)                                r_overflow <= 1'b1;
         else if (w_io_wr && w_io_off == OFF_STATUS) r_overflow <= 1'b0;

         if (vsync_pulse)      r_vsync_seen <= 1'b1;
         else if (w_status_rd) r_vsync_seen <= 1'b0;
      end
   end

   // NOTE: FIFO storage is not reset; entries are only visible when count says they are valid.
   always_ff @(posedge clock) begin
      if (w_push) r_fifo_mem[r_wr_ptr] <= key_code;
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed testbench for mmio_bridge: decode, display registers, key FIFO,
// status flags and asynchronous reset, all against hand-computed values.
module tb_mmio_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] proc_addr;
   logic [31:0] proc_wdata;
   logic        proc_wren;
   logic        proc_ren;
   logic [31:0] proc_rdata;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_wren;
   logic [31:0] dmem_q;
   logic [7:0]  key_code;
   logic        key_valid;
   logic        vsync_pulse;
   logic [9:0]  player_x;
   logic [8:0]  player_y;
   logic [7:0]  scene_id;
   logic [31:0] score;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rd;

   mmio_bridge #(.KEY_DEPTH(8), .IO_BASE(12'hFF0)) dut (
      .clock(clock), .reset(reset),
      .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_wren(proc_wren),
      .proc_ren(proc_ren), .proc_rdata(proc_rdata),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wren(dmem_wren),
      .dmem_q(dmem_q), .key_code(key_code), .key_valid(key_valid),
      .vsync_pulse(vsync_pulse), .player_x(player_x), .player_y(player_y),
      .scene_id(scene_id), .score(score)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      proc_addr   = 12'h000;
      proc_wdata  = 32'h0;
      proc_wren   = 1'b0;
      proc_ren    = 1'b0;
      key_code    = 8'h00;
      key_valid   = 1'b0;
      vsync_pulse = 1'b0;
   endtask

   // Each bus task starts just after a rising edge and ends just after the next one.
   task automatic sw(input logic [11:0] addr, input logic [31:0] data, input logic exp_wren);
      proc_addr = addr; proc_wdata = data; proc_wren = 1'b1;
      @(negedge clock);
      check($sformatf("dmem_wren@%03h", addr), {31'b0, dmem_wren}, {31'b0, exp_wren});
      @(posedge clock); #1;
      idle();
   endtask

   task automatic lw(input logic [11:0] addr, output logic [31:0] data);
      proc_addr = addr; proc_ren = 1'b1;
      @(negedge clock);
      data = proc_rdata;
      @(posedge clock); #1;
      idle();
   endtask

   task automatic push_key(input logic [7:0] code);
      key_code = code; key_valid = 1'b1;
      @(posedge clock); #1;
      idle();
   endtask

   task automatic fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) push_key(base + 8'(i));
   endtask

   task automatic drain_check(input string tag, input logic [7:0] base, input int n);
      logic [31:0] v;
      for (int i = 0; i < n; i++) begin
         lw(12'hFFF, v);
         check($sformatf("%s[%0d]", tag, i), v, {24'b0, base + 8'(i)});
      end
   endtask

   initial begin
      idle();
      dmem_q = 32'h1357_2468;
      reset  = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;

      // Reset state
      check("rst_player_x", {22'b0, player_x}, 32'h0);
      check("rst_score", score, 32'h0);
      lw(12'hFFE, rd); check("rst_status", rd, 32'h0);

      // Display registers
      sw(12'hFF0, 32'h0000_0123, 1'b0);
      sw(12'hFF1, 32'h0000_01FF, 1'b0);
      check("player_x", {22'b0, player_x}, 32'h123);
      check("player_y", {23'b0, player_y}, 32'h1FF);
      lw(12'hFF0, rd); check("lw_ff0", rd, 32'h123);
      sw(12'hFF2, 32'h0000_01A5, 1'b0);
      sw(12'hFF3, 32'hCAFE_F00D, 1'b0);
      check("scene_id", {24'b0, scene_id}, 32'hA5);
      check("score", score, 32'hCAFE_F00D);
      lw(12'hFF1, rd); check("lw_ff1", rd, 32'h1FF);

      // Pass-through and unmapped window
      proc_addr = 12'h010; proc_wdata = 32'hDEAD_BEEF; proc_wren = 1'b1;
      @(negedge clock);
      check("dmem_wren_pass", {31'b0, dmem_wren}, 32'h1);
      check("dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
      check("dmem_addr", {20'b0, dmem_addr}, 32'h010);
      @(posedge clock); #1; idle();
      lw(12'h010, rd); check("lw_dmem", rd, 32'h1357_2468);
      lw(12'hFF5, rd); check("lw_unmapped", rd, 32'h0);
      sw(12'hFF7, 32'hFFFF_FFFF, 1'b0);
      check("unmapped_wr_x", {22'b0, player_x}, 32'h123);
      check("unmapped_wr_score", score, 32'hCAFE_F00D);

      // Basic FIFO ordering and pop on empty
      push_key(8'h1C); push_key(8'h32); push_key(8'h21);
      lw(12'hFFE, rd); check("status_3", rd, 32'h7);
      lw(12'hFFF, rd); check("pop0", rd, 32'h1C);
      lw(12'hFFF, rd); check("pop1", rd, 32'h32);
      lw(12'hFFF, rd); check("pop2", rd, 32'h21);
      lw(12'hFFF, rd); check("pop_empty", rd, 32'h0);
      lw(12'hFFE, rd); check("status_empty", rd, 32'h0);

      // Overflow: ninth key dropped, cleared by a status write
      fill(8'h40, 9);
      lw(12'hFFE, rd); check("status_ovf", rd, 32'h111);
      sw(12'hFFE, 32'h0, 1'b0);
      lw(12'hFFE, rd); check("status_ovf_clr", rd, 32'h011);
      drain_check("drain_ovf", 8'h40, 8);
      lw(12'hFFF, rd); check("ninth_absent", rd, 32'h0);

      // Full FIFO with simultaneous push and pop
      fill(8'h50, 8);
      proc_addr = 12'hFFF; proc_ren = 1'b1; key_code = 8'h99; key_valid = 1'b1;
      @(negedge clock); rd = proc_rdata;
      @(posedge clock); #1; idle();
      check("full_pushpop_head", rd, 32'h50);
      lw(12'hFFE, rd); check("full_pushpop_status", rd, 32'h011);
      drain_check("drain_full", 8'h51, 7);
      lw(12'hFFF, rd); check("full_new_last", rd, 32'h99);

      // Push and pop with a single entry
      push_key(8'h11);
      proc_addr = 12'hFFF; proc_ren = 1'b1; key_code = 8'h22; key_valid = 1'b1;
      @(negedge clock); rd = proc_rdata;
      @(posedge clock); #1; idle();
      check("one_pushpop_head", rd, 32'h11);
      lw(12'hFFE, rd); check("one_pushpop_status", rd, 32'h3);
      lw(12'hFFF, rd); check("one_pushpop_next", rd, 32'h22);

      // Overflow set wins over a clearing write in the same cycle
      fill(8'h60, 8);
      proc_addr = 12'hFFE; proc_wren = 1'b1; key_code = 8'hEE; key_valid = 1'b1;
      @(posedge clock); #1; idle();
      lw(12'hFFE, rd); check("ovf_set_wins", rd, 32'h111);
      sw(12'hFFE, 32'h1, 1'b0);
      drain_check("drain_setwins", 8'h60, 8);

      // vsync sticky flag, cleared by status read, set wins over clear
      vsync_pulse = 1'b1; @(posedge clock); #1; idle();
      lw(12'hFFE, rd); check("vsync_seen", rd, 32'h200);
      lw(12'hFFE, rd); check("vsync_cleared", rd, 32'h0);
      proc_addr = 12'hFFE; proc_ren = 1'b1; vsync_pulse = 1'b1;
      @(posedge clock); #1; idle();
      lw(12'hFFE, rd); check("vsync_set_wins", rd, 32'h200);

      // Asynchronous reset with keys queued
      fill(8'h70, 5);
      lw(12'hFFE, rd); check("pre_reset_status", rd, 32'hB);
      #2;
      proc_addr = 12'hFFE;
      reset = 1'b0;
      #1;
      check("async_rst_status", proc_rdata, 32'h0);
      check("async_rst_player_x", {22'b0, player_x}, 32'h0);
      check("async_rst_dmem_wren", {31'b0, dmem_wren}, 32'h0);
      @(negedge clock); reset = 1'b1; idle();
      @(posedge clock); #1;
      push_key(8'h77);
      lw(12'hFFE, rd); check("post_reset_status", rd, 32'h3);
      lw(12'hFFF, rd); check("post_reset_key", rd, 32'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
